// File: rtl/vdp18_pkg.sv
// Shared VDP types plus the VRAM slot map.
// slot_decode tells which fixed fetch, if any, owns a slot.
package vdp18_pkg;

   typedef enum logic [3:0] {
      AC_NONE,
      AC_PNT,
      AC_PCT,
      AC_PGT,
      AC_SATY,
      AC_SATX,
      AC_SATN,
      AC_SATC,
      AC_SPTH,
      AC_SPTL,
      AC_CPU
   } access_t;

   typedef enum logic [1:0] {
      OP_GRAPH1,
      OP_GRAPH2,
      OP_MULTIC,
      OP_TEXTM
   } opmode_t;

   localparam logic [7:0] SLOTS_PER_LINE = 8'd171;
   localparam logic [7:0] ACT_SLOTS      = 8'd128;
   localparam logic [7:0] SPR_SLOTS      = 8'd32;
   localparam logic [7:0] LAST_SLOT      = SLOTS_PER_LINE - 8'd1;
   localparam logic [7:0] SPR_END        = ACT_SLOTS + SPR_SLOTS;

   typedef struct packed {
      access_t    ac;
      logic [4:0] tile;
      logic [1:0] spr;
   } slot_dec_t;

   function automatic slot_dec_t slot_decode(
      input logic [7:0] s,
      input opmode_t    mode,
      input logic       disp_en,
      input logic       spr_en
   );
      slot_dec_t  r;
      logic [7:0] o;
      r.ac   = AC_NONE;
      r.tile = '0;
      r.spr  = '0;
      o      = s - ACT_SLOTS;
      if (disp_en) begin
         if (s < ACT_SLOTS) begin
            r.tile = s[6:2];
            unique case (mode)
               OP_GRAPH1, OP_GRAPH2: begin
                  case (s[1:0])
                     2'd0:    r.ac = AC_PNT;
                     2'd1:    r.ac = AC_PCT;
                     2'd2:    r.ac = AC_PGT;
                     default: r.ac = AC_NONE;
                  endcase
               end
               OP_MULTIC, OP_TEXTM: begin
                  case (s[1:0])
                     2'd0:    r.ac = AC_PNT;
                     2'd1:    r.ac = AC_PGT;
                     default: r.ac = AC_NONE;
                  endcase
               end
            endcase
         end else if (s < SPR_END && spr_en && mode != OP_TEXTM) begin
            r.spr = o[4:3];
            case (o[2:0])
               3'd0:    r.ac = AC_SATY;
               3'd1:    r.ac = AC_SATX;
               3'd2:    r.ac = AC_SATN;
               3'd3:    r.ac = AC_SATC;
               3'd4:    r.ac = AC_SPTH;
               3'd5:    r.ac = AC_SPTL;
               default: r.ac = AC_NONE;
            endcase
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/vdp18_cpu_req_buf.sv
// One-deep CPU VRAM request buffer: accept/drop, busy/done/overrun
// and read-data capture on completion.
module vdp18_cpu_req_buf (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        cpu_req_i,
   input  logic        cpu_we_i,
   input  logic [13:0] cpu_a_i,
   input  logic [7:0]  cpu_d_i,
   input  logic        complete_i,
   input  logic [7:0]  vram_d_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        ovr_o,
   output logic [7:0]  rd_d_o,
   output logic        we_o,
   output logic [13:0] a_o,
   output logic [7:0]  d_o
);

   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ovr_q, ovr_d;
   logic        we_q, we_d;
   logic [13:0] a_q, a_d;
   logic [7:0]  d_q, d_d;
   logic [7:0]  rd_q, rd_d;
   logic        accept;

   always_comb begin
      accept = cpu_req_i & (~busy_q | complete_i);
      busy_d = busy_q;
      we_d   = we_q;
      a_d    = a_q;
      d_d    = d_q;
      rd_d   = rd_q;
      done_d = complete_i;
      ovr_d  = cpu_req_i & ~accept;
      if (complete_i) begin
         busy_d = 1'b0;
         if (!we_q) rd_d = vram_d_i;
      end
      // a request landing on the completing edge takes over with no idle gap
      if (accept) begin
         busy_d = 1'b1;
         we_d   = cpu_we_i;
         a_d    = cpu_a_i;
         d_d    = cpu_d_i;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         ovr_q  <= 1'b0;
         we_q   <= 1'b0;
         a_q    <= '0;
         d_q    <= '0;
         rd_q   <= '0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         ovr_q  <= ovr_d;
         we_q   <= we_d;
         a_q    <= a_d;
         d_q    <= d_d;
         rd_q   <= rd_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign ovr_o  = ovr_q;
   assign rd_d_o = rd_q;
   assign we_o   = we_q;
   assign a_o    = a_q;
   assign d_o    = d_q;

endmodule

// File: rtl/vdp18_vram_slot_sched.sv
// VRAM slot scheduler: slot counter, per-slot access decode and
// CPU grant into slots left free by display and sprite fetches.
module vdp18_vram_slot_sched
   import vdp18_pkg::*;
(
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        slot_strobe_i,
   input  logic        line_start_i,
   input  logic        disp_en_i,
   input  logic        spr_en_i,
   input  opmode_t     opmode_i,
   input  logic        cpu_req_i,
   input  logic        cpu_we_i,
   input  logic [13:0] cpu_a_i,
   input  logic [7:0]  cpu_d_i,
   output logic        cpu_busy_o,
   output logic        cpu_done_o,
   output logic        cpu_ovr_o,
   output logic [7:0]  cpu_rd_d_o,
   output logic [13:0] cpu_vram_a_o,
   input  logic [7:0]  vram_d_i,
   output logic [7:0]  vram_d_o,
   output logic        vram_we_o,
   output access_t     access_type_o,
   output logic [4:0]  tile_num_o,
   output logic [1:0]  spr_slot_o
);

   logic [7:0] slot_cnt_q, slot_cnt_d;
   access_t    ac_q, ac_d;
   logic [4:0] tile_q, tile_d;
   logic [1:0] spr_q, spr_d;
   logic       grant_q, grant_d;
   logic       vram_we_q, vram_we_d;
   logic [7:0] slot_nxt;
   slot_dec_t  dec;
   logic       evt;
   logic       complete;
   logic       buf_busy;
   logic       buf_we;

   assign evt      = slot_strobe_i | line_start_i;
   assign complete = evt & grant_q;

   always_comb begin
      slot_cnt_d = slot_cnt_q;
      ac_d       = ac_q;
      tile_d     = tile_q;
      spr_d      = spr_q;
      grant_d    = grant_q;
      vram_we_d  = vram_we_q;
      if (line_start_i || slot_cnt_q == LAST_SLOT) slot_nxt = 8'd0;
      else slot_nxt = slot_cnt_q + 8'd1;
      dec = slot_decode(slot_nxt, opmode_i, disp_en_i, spr_en_i);
      if (evt) begin
         slot_cnt_d = slot_nxt;
         tile_d     = dec.tile;
         spr_d      = dec.spr;
         // the request being completed on this edge must not be re-granted
         grant_d    = (dec.ac == AC_NONE) & buf_busy & ~grant_q;
         ac_d       = grant_d ? AC_CPU : dec.ac;
         vram_we_d  = grant_d & buf_we;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         slot_cnt_q <= '0;
         ac_q       <= AC_NONE;
         tile_q     <= '0;
         spr_q      <= '0;
         grant_q    <= 1'b0;
         vram_we_q  <= 1'b0;
      end else begin
         slot_cnt_q <= slot_cnt_d;
         ac_q       <= ac_d;
         tile_q     <= tile_d;
         spr_q      <= spr_d;
         grant_q    <= grant_d;
         vram_we_q  <= vram_we_d;
      end
   end

   vdp18_cpu_req_buf u_buf (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .cpu_req_i  (cpu_req_i),
      .cpu_we_i   (cpu_we_i),
      .cpu_a_i    (cpu_a_i),
      .cpu_d_i    (cpu_d_i),
      .complete_i (complete),
      .vram_d_i   (vram_d_i),
      .busy_o     (buf_busy),
      .done_o     (cpu_done_o),
      .ovr_o      (cpu_ovr_o),
      .rd_d_o     (cpu_rd_d_o),
      .we_o       (buf_we),
      .a_o        (cpu_vram_a_o),
      .d_o        (vram_d_o)
   );

   assign cpu_busy_o    = buf_busy;
   assign vram_we_o     = vram_we_q;
   assign access_type_o = ac_q;
   assign tile_num_o    = tile_q;
   assign spr_slot_o    = spr_q;

endmodule
